// File: rtl/serial_pattern_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package serial_pattern_pkg;

    localparam int MAX_LEN_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic int unsigned sat_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Job handshake and serial output bundle for serial_pattern_tx.
interface serial_pattern_tx_if
    import serial_pattern_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    logic               load_valid;
    logic               load_ready;
    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      len;
    logic [3:0]         repeats;
    logic [3:0]         gap_len;
    logic               idle_bit;
    logic               abort;
    logic               out_bit;
    logic               out_valid;
    logic               done;

    modport master (
        output load_valid, pattern, len, repeats, gap_len, idle_bit, abort,
        input  load_ready, out_bit, out_valid, done
    );

    modport slave (
        input  load_valid, pattern, len, repeats, gap_len, idle_bit, abort,
        output load_ready, out_bit, out_valid, done
    );

endinterface

// File: rtl/serial_pattern_shifter.sv
// Holds the latched pattern and the MSB-first bit index; exposes the bit
// each control action would present next so the caller can register it.
module serial_pattern_shifter
    import serial_pattern_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          restart,
    input  logic                          shift,
    input  logic [MAX_LEN-1:0]            pattern_in,
    input  logic [$clog2(MAX_LEN):0]      len_in,
    output logic                          load_bit,
    output logic                          restart_bit,
    output logic                          shift_bit,
    output logic                          last
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      top_q, top_d;
    logic [IW-1:0]      top_new;

    // len_in is already saturated and nonzero whenever a load matters
    assign top_new     = IW'(len_in - LW'(1));
    assign load_bit    = pattern_in[top_new];
    assign restart_bit = pat_q[top_q];
    assign shift_bit   = pat_q[idx_q - IW'(1)];
    assign last        = (idx_q == '0);

    always_comb begin
        pat_d = pat_q;
        top_d = top_q;
        idx_d = idx_q;
        if (load) begin
            pat_d = pattern_in;
            top_d = top_new;
            idx_d = top_new;
        end else if (restart) begin
            idx_d = top_q;
        end else if (shift) begin
            idx_d = idx_q - IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            top_q <= '0;
            idx_q <= '0;
        end else begin
            pat_q <= pat_d;
            top_q <= top_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated
// with optional idle gaps, and pulses done after the final bit.
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    serial_pattern_tx_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    state_e      state_q, state_d;
    logic [3:0]  pass_q, pass_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [3:0]  gap_len_q, gap_len_d;
    logic        idle_q, idle_d;
    logic        out_bit_q, out_bit_d;
    logic        out_valid_q, out_valid_d;
    logic        done_q, done_d;

    logic [LW-1:0] len_sat;
    logic          sh_load, sh_restart, sh_shift;
    logic          sh_load_bit, sh_restart_bit, sh_shift_bit, sh_last;

    assign len_sat = LW'(sat_len(int'(bus.len), MAX_LEN));

    serial_pattern_shifter #(.MAX_LEN(MAX_LEN)) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load        (sh_load),
        .restart     (sh_restart),
        .shift       (sh_shift),
        .pattern_in  (bus.pattern),
        .len_in      (len_sat),
        .load_bit    (sh_load_bit),
        .restart_bit (sh_restart_bit),
        .shift_bit   (sh_shift_bit),
        .last        (sh_last)
    );

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        gap_cnt_d   = gap_cnt_q;
        gap_len_d   = gap_len_q;
        idle_d      = idle_q;
        out_bit_d   = idle_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        sh_load     = 1'b0;
        sh_restart  = 1'b0;
        sh_shift    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    sh_load   = 1'b1;
                    pass_d    = bus.repeats;
                    gap_len_d = bus.gap_len;
                    idle_d    = bus.idle_bit;
                    out_bit_d = bus.idle_bit;
                    // Empty job: nothing to send, finish straight away
                    if (len_sat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_SEND;
                        out_bit_d   = sh_load_bit;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (!sh_last) begin
                    sh_shift    = 1'b1;
                    out_bit_d   = sh_shift_bit;
                    out_valid_d = 1'b1;
                end else if (pass_q != 4'd0) begin
                    pass_d = pass_q - 4'd1;
                    if (gap_len_q != 4'd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_len_q;
                    end else begin
                        sh_restart  = 1'b1;
                        out_bit_d   = sh_restart_bit;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == 4'd1) begin
                    state_d     = ST_SEND;
                    sh_restart  = 1'b1;
                    out_bit_d   = sh_restart_bit;
                    out_valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pass_q      <= '0;
            gap_cnt_q   <= '0;
            gap_len_q   <= '0;
            idle_q      <= 1'b0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_len_q   <= gap_len_d;
            idle_q      <= idle_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.load_ready = (state_q == ST_IDLE);
    assign bus.out_bit    = out_bit_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: table of directed jobs, async reset mid-gap,
// then random jobs against a per-cycle expected-stream model.
module tb_serial_pattern_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_pattern_tx_if #(.MAX_LEN(16)) bus ();

    serial_pattern_tx #(.MAX_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic v;
        logic b;
        logic d;
    } cyc_t;

    typedef struct {
        logic [15:0] pat;
        int          len;
        int          rep;
        int          gap;
        logic        ib;
        int          abort_at;
        logic [15:0] det_pat;
        int          det_len;
        int          exp_bits;
        int          exp_hits;
        int          exp_done;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic quiet();
        bus.load_valid = 1'b0;
        bus.abort      = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic ib);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_valid", bus.out_valid, 1'b0);
            chk("idle_done", bus.done, 1'b0);
            chk("idle_ready", bus.load_ready, 1'b1);
            chk("idle_bit", bus.out_bit, ib);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns with the DUT idle.
    task automatic run_job(input logic [15:0] p, input int l, input int r, input int g,
                           input logic ib, input int abort_at,
                           input logic [15:0] det_pat, input int det_len,
                           output int nbits, output int nhits, output int ndone);
        cyc_t        q[$];
        int          n;
        logic [15:0] sh;
        logic [15:0] mask;
        n = (l > 16) ? 16 : l;
        if (n > 0) begin
            for (int ps = 0; ps <= r; ps++) begin
                for (int i = n - 1; i >= 0; i--) q.push_back({1'b1, p[i], 1'b0});
                if (ps < r) for (int j = 0; j < g; j++) q.push_back({1'b0, ib, 1'b0});
            end
        end
        q.push_back({1'b0, ib, 1'b1});

        nbits = 0; nhits = 0; ndone = 0; sh = '0;
        mask  = 16'((32'h1 << det_len) - 1);
        bus.load_valid = 1'b1;
        bus.pattern    = p;
        bus.len        = 5'(l);
        bus.repeats    = 4'(r);
        bus.gap_len    = 4'(g);
        bus.idle_bit   = ib;
        bus.abort      = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        for (int k = 1; k <= q.size(); k++) begin
            chk("out_valid", bus.out_valid, q[k-1].v);
            chk("out_bit", bus.out_bit, q[k-1].b);
            chk("done", bus.done, q[k-1].d);
            chk("load_ready", bus.load_ready, (k == q.size()) ? 1 : 0);
            if (bus.out_valid) begin
                nbits++;
                sh = {sh[14:0], bus.out_bit};
                if (det_len > 0 && nbits >= det_len && (sh & mask) == det_pat) nhits++;
            end
            if (bus.done) ndone++;
            if (k == q.size()) begin
                quiet();
                break;
            end
            if (k == abort_at) begin
                bus.abort      = 1'b1;
                bus.load_valid = 1'b0;
                @(posedge clk); #1;
                chk("abort_valid", bus.out_valid, 1'b0);
                chk("abort_bit", bus.out_bit, ib);
                chk("abort_done", bus.done, 1'b0);
                chk("abort_ready", bus.load_ready, 1'b1);
                bus.abort = 1'b0;
                @(posedge clk); #1;
                chk("post_abort_valid", bus.out_valid, 1'b0);
                chk("post_abort_done", bus.done, 1'b0);
                break;
            end
            // Inputs churn while busy; the running job must not notice
            bus.pattern    = 16'($urandom);
            bus.len        = 5'($urandom);
            bus.repeats    = 4'($urandom);
            bus.gap_len    = 4'($urandom);
            bus.idle_bit   = 1'($urandom);
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.abort      = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   nb, nh, nd;
        logic ib_now;

        vecs[0] = '{16'h0033, 6,  0,  0, 1'b0, 0,  16'h0033, 6, 6,  1, 1};
        vecs[1] = '{16'h000A, 4,  2,  0, 1'b0, 0,  16'h000A, 4, 12, 5, 1};
        vecs[2] = '{16'h0005, 3,  1,  2, 1'b1, 0,  16'h0000, 0, 6,  0, 1};
        vecs[3] = '{16'h00B7, 8,  0,  0, 1'b0, 3,  16'h0000, 0, 3,  0, 0};
        vecs[4] = '{16'hFFFF, 0,  3,  5, 1'b1, 0,  16'h0000, 0, 0,  0, 1};
        vecs[5] = '{16'hA5C3, 20, 0,  0, 1'b0, 0,  16'h0000, 0, 16, 0, 1};
        vecs[6] = '{16'h0001, 1,  15, 15, 1'b1, 0, 16'h0000, 0, 16, 0, 1};
        vecs[7] = '{16'h1234, 16, 1,  1, 1'b0, 20, 16'h0000, 0, 19, 0, 0};
        vecs[8] = '{16'h0005, 3,  1,  4, 1'b1, 5,  16'h0000, 0, 3,  0, 0};

        bus.load_valid = 1'b0; bus.pattern = '0; bus.len = '0; bus.repeats = '0;
        bus.gap_len = '0; bus.idle_bit = 1'b0; bus.abort = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_bit", bus.out_bit, 1'b0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_ready", bus.load_ready, 1'b1);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_job(vecs[i].pat, vecs[i].len, vecs[i].rep, vecs[i].gap, vecs[i].ib,
                    vecs[i].abort_at, vecs[i].det_pat, vecs[i].det_len, nb, nh, nd);
            chk($sformatf("vec%0d_bits", i), nb, vecs[i].exp_bits);
            chk($sformatf("vec%0d_hits", i), nh, vecs[i].exp_hits);
            chk($sformatf("vec%0d_done", i), nd, vecs[i].exp_done);
            idle_cycles(i % 3, vecs[i].ib);
        end

        // Async reset in the middle of a gap
        bus.load_valid = 1'b1; bus.pattern = 16'h0005; bus.len = 5'd3;
        bus.repeats = 4'd1; bus.gap_len = 4'd4; bus.idle_bit = 1'b1; bus.abort = 1'b0;
        @(posedge clk); #1;
        quiet();
        repeat (4) @(posedge clk);
        #1;
        chk("gap_valid", bus.out_valid, 1'b0);
        chk("gap_bit", bus.out_bit, 1'b1);
        chk("gap_ready", bus.load_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_bit", bus.out_bit, 1'b0);
        chk("arst_valid", bus.out_valid, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_ready", bus.load_ready, 1'b1);
        @(posedge clk); #3 rst = 1'b0;
        idle_cycles(3, 1'b0);
        run_job(16'h00C5, 8, 1, 2, 1'b0, 0, 16'h0000, 0, nb, nh, nd);
        chk("after_rst_bits", nb, 16);
        chk("after_rst_done", nd, 1);

        for (int t = 0; t < 40; t++) begin
            ib_now = 1'($urandom);
            run_job(16'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), ib_now,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0,
                    16'h0000, 0, nb, nh, nd);
            idle_cycles(int'($urandom_range(0, 2)), ib_now);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum pattern length in bits.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port load_valid  input  1  a new transmit job is offered.
REQ-005 SHALL have port load_ready  output  1  block can accept a job.
REQ-006 SHALL have port pattern  input  MAX_LEN  bits to send; the used field is pattern[len-1:0].
REQ-007 SHALL have port len  input  $clog2(MAX_LEN)+1  pattern length in bits.
REQ-008 SHALL have port repeats  input  4  number of additional passes, 0..15.
REQ-009 SHALL have port gap_len  input  4  idle cycles inserted between passes.
REQ-010 SHALL have port idle_bit  input  1  line level driven when no data bit is being sent.
REQ-011 SHALL have port abort  input  1  synchronous job cancel.
REQ-012 SHALL have port out_bit  output  1  serial data, registered.
REQ-013 SHALL have port out_valid  output  1  out_bit carries a pattern bit this cycle, registered.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last bit of a job, registered.

Function
REQ-015 SHALL implement the states IDLE, SEND and GAP.
REQ-016 SHALL drive load_ready=1 only in IDLE; a job is accepted at an edge where load_valid & load_ready are both 1.
REQ-017 SHALL latch pattern, len, repeats, gap_len and idle_bit on accept; later input changes SHALL NOT affect the running job.
REQ-018 SHALL transmit MSB-first: pattern[len-1] in the first cycle after accept, pattern[0] last, so that a downstream shift-left detector sees the pattern in written order.
REQ-019 SHALL send one bit per cycle with out_valid=1 throughout SEND; there SHALL be no bubbles inside a pass.
REQ-020 After the last bit of a pass, with passes remaining:
  - gap_len>0: enter GAP for exactly gap_len cycles, with out_bit=idle_bit and out_valid=0.
  - gap_len=0: start the next pass in the very next cycle, back-to-back.
REQ-021 SHALL send exactly len*(repeats+1) data bits per job.
REQ-022 After the final bit, SHALL enter IDLE at the next edge and assert done for that one cycle; out_bit=latched idle_bit and out_valid=0 while IDLE.
REQ-023 SHALL saturate len>MAX_LEN to MAX_LEN.
REQ-024 For len=0, SHALL accept the job, send no bits and no gap, and pulse done in the cycle after accept.
REQ-025 When abort=1 in SEND or GAP, SHALL enter IDLE at the next edge:
  - out_valid=0, out_bit=idle_bit;
  - done SHALL NOT pulse.
REQ-026 SHALL ignore abort in IDLE; when abort and load_valid are both 1 in IDLE, the load SHALL be accepted.
REQ-027 SHALL NOT accept a new job in the cycle done is asserted; load_ready rises together with done, and the earliest accept is the edge ending the done cycle.

Reset
REQ-028 On rst: state=IDLE, out_bit=0, out_valid=0, done=0, load_ready=1, all counters and latched fields=0.
REQ-029 rst asserted mid-job SHALL abandon the job immediately, with no done pulse and no residual bits after release.

Structure
REQ-030 SHALL place the state enum and the MAX_LEN default in package serial_pattern_pkg.
REQ-031 SHALL implement the bit selection and bit-index counter in one sub-module, serial_pattern_shifter (load, shift-enable, last-bit flag); the FSM, pass counter and gap counter stay in the top.

Verification
REQ-032 Load 110011, len=6, repeats=0, gap=0, idle=0 -> out_bit 1,1,0,0,1,1 in cycles 1..6 with out_valid=1; done in cycle 7; a 110011 shift-register detector fed out_bit asserts exactly once.
REQ-033 Load 1010, len=4, repeats=2, gap=0 -> 12 contiguous valid bits 101010101010; a 1010 detector asserts at bits 4, 6, 8, 10 and 12; done once.
REQ-034 Load 101, len=3, repeats=1, gap=2, idle=1 -> 1,0,1, then 2 cycles out_bit=1 with out_valid=0, then 1,0,1; done in the following cycle.
REQ-035 Assert abort on the 3rd bit of a len=8 job -> out_valid=0 from the next cycle, no done, load_ready=1.
REQ-036 Job with len=0 -> no valid bits, done in cycle 1; job with len=20 and MAX_LEN=16 -> exactly 16 bits sent.
REQ-037 Assert rst asynchronously mid-GAP -> outputs at reset values without waiting for a clock edge; a job loaded after release runs normally.
